// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between
// NUM_REQ requesters and returns each result on a single tagged response channel.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   per-requester handshake (req_ready combinational, one-hot or 0)
//   req_op/rs1/rs2          packed per-requester payloads, requester i in slice i
//   alu_op/rs1/rs2          registered operands driven into the external ALU
//   alu_result              combinational ALU result
//   rsp_valid / rsp_ready   response handshake
//   rsp_id/data/err         owner, captured result, unsupported-opcode flag
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [4*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_rs1,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_rs2,
    output logic [3:0]                    alu_op,
    output logic [DATA_WIDTH-1:0]         alu_rs1,
    output logic [DATA_WIDTH-1:0]         alu_rs2,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err
);

    localparam int unsigned OP_W  = 4;
    // One extra bit so ptr + k (k up to NUM_REQ) never overflows before the wrap.
    localparam int unsigned IDX_W = ID_W + 1;
    localparam logic [OP_W-1:0] FIRST_BAD_OP = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
    } alu_req_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    alu_req_t              alu_q, alu_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  grant_win;
    logic                  found;
    logic [ID_W-1:0]       winner;
    logic [IDX_W-1:0]      cand;

    alu_req_t              pay_arr [NUM_REQ];

    // Unpack the flat per-requester buses into one payload per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign pay_arr[g] = '{op:  req_op[OP_W*g +: OP_W],
                              rs1: req_rs1[DATA_WIDTH*g +: DATA_WIDTH],
                              rs2: req_rs2[DATA_WIDTH*g +: DATA_WIDTH]};
    end

    // Round-robin search, grant and next-state logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        alu_d       = alu_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        found       = 1'b0;
        winner      = '0;
        cand        = '0;

        // rst_n gates the window so req_ready stays low while held in reset.
        grant_win = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

        // First valid requester after ptr, wrapping modulo NUM_REQ.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'(ptr_q) + IDX_W'(k);
            if (cand >= IDX_W'(NUM_REQ)) begin
                cand = cand - IDX_W'(NUM_REQ);
            end
            if (!found && req_valid[ID_W'(cand)]) begin
                found  = 1'b1;
                winner = ID_W'(cand);
            end
        end

        case (state_q)
            IDLE: ;
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_id_d    = id_q;
                rsp_err_d   = (alu_q.op >= FIRST_BAD_OP);
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant overrides the fall-back to IDLE from RESP.
        if (grant_win && found) begin
            req_ready[winner] = 1'b1;
            alu_d             = pay_arr[winner];
            id_d              = winner;
            ptr_d             = winner;
            state_d           = EXEC;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            alu_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            alu_q       <= alu_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_op    = alu_q.op;
    assign alu_rs1   = alu_q.rs1;
    assign alu_rs2   = alu_q.rs2;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
